bpsk_frame_generator: RTL and testbench
=======================================

Name: bpsk_frame_generator

Overview:
- Framed BPSK symbol source; replaces the free-running sample generator as the upstream feed of the 4x upsampler / pulse-shaping chain.
- Emits repeating frames on a symbol tick derived from the sample clock: Barker-13 preamble, 16-bit sync word, PRBS7 payload, zero-level guard gap.
- Bits map to signed 8-bit antipodal levels suitable for direct input to the shaping FIR.

Parameters:
- SYM_DIV, 4, sample clocks per symbol (>=2); matches the upsampling factor.
- AMPLITUDE, 64, magnitude of the symbol level (1..127).
- SYNC_WORD, 16'h1ACF, sync word, sent MSB first.
- PAYLOAD_LEN, 64, payload symbols per frame (1..4096).
- GAP_LEN, 8, zero-level symbols after the payload (0..255; 0 skips GAP).

Ports:
- clock  in  1  sample clock (the 4 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high requests continuous framing.
- symbol  out  8  signed symbol level: +AMPLITUDE, -AMPLITUDE or 0.
- symbol_valid  out  1  one-clock pulse in the cycle `symbol` takes a new value.
- bit_out  out  1  bit currently being sent (0 in IDLE/GAP).
- frame_start  out  1  one-clock pulse with the first preamble symbol_valid.
- busy  out  1  high in any state other than IDLE.
- state  out  3  IDLE=0, PREAMBLE=1, SYNC=2, PAYLOAD=3, GAP=4.

Behaviour:
- Reset is asynchronous on reset_n low. It clears all outputs to 0, state to IDLE, the divider to 0 and all counters, and loads the LFSR with 7'h7F. Reset mid-frame aborts immediately with no completion.
- Divider: free-runs 0..SYM_DIV-1 from reset release. tick = (div == SYM_DIV-1). State, counters, symbol, bit_out and the LFSR update only on a tick edge.
- All outputs are registered. symbol_valid and frame_start are high for exactly the one cycle after the updating tick edge. symbol_valid pulses on every tick in every non-IDLE state, and on the tick that returns to IDLE.
- Mapping: bit 0 -> +AMPLITUDE; bit 1 -> -AMPLITUDE. IDLE and GAP -> 0.
- IDLE: on a tick with enable=1, go to PREAMBLE and output Barker bit 0. Otherwise hold symbol=0.
- PREAMBLE: sends 13 symbols of 1111100110101, left bit first. After bit 12, go to SYNC.
- SYNC: sends SYNC_WORD[15] down to [0]. After bit 0, go to PAYLOAD.
- PAYLOAD:
  - The LFSR is reseeded to 7'h7F on entry, so every frame's payload is identical.
  - Output bit = lfsr[6]. Next lfsr = {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1).
  - First 8 payload bits are 1,1,1,1,1,1,1,0.
  - After PAYLOAD_LEN symbols, go to GAP, or to PREAMBLE/IDLE if GAP_LEN=0.
- GAP: holds symbol=0 for GAP_LEN symbols. At the end, go to PREAMBLE if enable=1 (frame_start pulses again), else IDLE.
- enable deassert mid-frame has no effect until the frame completes, including the gap. Only the end-of-gap (or IDLE) decision samples enable.
- enable re-asserted during GAP is honoured at the end of GAP with no extra IDLE symbol.
- Frame length = 29 + PAYLOAD_LEN + GAP_LEN symbols. Defaults give 101 symbols = 404 clocks.
- Symbol counter: 12 bits, reused per state, cleared on each state change. There is no overflow by parameter bounds.
- Latency: first symbol_valid occurs at most SYM_DIV clocks after enable is sampled high in IDLE.

Test Plan:
- Reset then enable=1 with defaults -> frame_start and the first symbol_valid coincide, symbol=-64 (Barker bit 1); symbol_valid spacing is exactly 4 clocks.
- Capture one full frame -> 13 preamble bits 1111100110101, sync bits 0001101011001111, payload starting 11111110, then 8 zeros; frame_start repeats exactly 404 clocks later.
- Capture 2 frames -> payload bits are identical; the 127-bit PRBS7 period is verified with PAYLOAD_LEN=200 (bits 0 and 127 match).
- Drop enable at payload symbol 10 -> frame finishes through GAP, then IDLE, busy=0, symbol=0, no further symbol_valid.
- Assert reset_n low in SYNC -> all outputs 0 and state=0 immediately, asynchronously; after release with enable=1 the frame restarts from the preamble.
- GAP_LEN=0, AMPLITUDE=127, SYM_DIV=2 -> payload's last symbol is followed directly by preamble symbol -127; spacing is 2 clocks.

Source files
------------

// File: rtl/bpsk_frame_generator.sv
// Framed BPSK symbol source: Barker-13 preamble, sync word, PRBS7 payload and a
// zero-level guard gap, emitting one antipodal 8-bit level every SYM_DIV clocks.
module bpsk_frame_generator #(
  parameter int          SYM_DIV     = 4,
  parameter int          AMPLITUDE   = 64,
  parameter logic [15:0] SYNC_WORD   = 16'h1ACF,
  parameter int          PAYLOAD_LEN = 64,
  parameter int          GAP_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic [7:0] symbol,
  output logic       symbol_valid,
  output logic       bit_out,
  output logic       frame_start,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SYNC     = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam int               DIV_W     = $clog2(SYM_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
  // Barker-13 left-aligned in 16 bits so it indexes like the sync word
  localparam logic [15:0]      BARKER    = 16'b1111_1001_1010_1000;
  localparam logic [7:0]       LVL_POS   = 8'(AMPLITUDE);
  localparam logic [7:0]       LVL_NEG   = 8'(-AMPLITUDE);
  localparam logic [11:0]      PAY_LAST  = 12'(PAYLOAD_LEN - 1);
  localparam logic [11:0]      GAP_LAST  = (GAP_LEN > 0) ? 12'(GAP_LEN - 1) : 12'd0;
  localparam logic [6:0]       LFSR_SEED = 7'h7F;

  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [11:0]      r_cnt;
  logic [6:0]       r_lfsr;
  logic [7:0]       r_symbol;
  logic             r_symbol_valid;
  logic             r_bit;
  logic             r_frame_start;
  logic             r_busy;

  logic       w_tick;
  logic       w_frame_end;
  logic       w_start;
  logic       w_pre_bit;
  logic       w_sync_bit;
  logic [6:0] w_lfsr_next;

  assign w_tick      = (r_div == DIV_LAST);
  // Last symbol of the frame: end of gap, or end of payload when there is no gap
  assign w_frame_end = ((r_state == S_PAYLOAD) && (r_cnt == PAY_LAST) && (GAP_LEN == 0)) ||
                       ((r_state == S_GAP) && (r_cnt == GAP_LAST));
  assign w_start     = enable && ((r_state == S_IDLE) || w_frame_end);
  assign w_pre_bit   = BARKER[4'd14 - r_cnt[3:0]];
  assign w_sync_bit  = SYNC_WORD[4'd14 - r_cnt[3:0]];
  assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

  function automatic logic [7:0] level(input logic b);
    return b ? LVL_NEG : LVL_POS;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div          <= '0;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_lfsr         <= LFSR_SEED;
      r_symbol       <= '0;
      r_symbol_valid <= 1'b0;
      r_bit          <= 1'b0;
      r_frame_start  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_symbol_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_div          <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_symbol_valid <= (r_state != S_IDLE) || enable;
        if (w_start) begin
          r_state       <= S_PREAMBLE;
          r_busy        <= 1'b1;
          r_cnt         <= '0;
          r_frame_start <= 1'b1;
          r_bit         <= BARKER[15];
          r_symbol      <= level(BARKER[15]);
        end else if (w_frame_end) begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_bit    <= 1'b0;
          r_symbol <= '0;
        end else begin
          case (r_state)
            S_PREAMBLE: begin
              if (r_cnt == 12'd12) begin
                r_state  <= S_SYNC;
                r_cnt    <= '0;
                r_bit    <= SYNC_WORD[15];
                r_symbol <= level(SYNC_WORD[15]);
              end else begin
                r_cnt    <= r_cnt + 12'd1;
                r_bit    <= w_pre_bit;
                r_symbol <= level(w_pre_bit);
              end
            end
            S_SYNC: begin
              if (r_cnt == 12'd15) begin
                // Reseed on entry so every frame carries the same payload
                r_state  <= S_PAYLOAD;
                r_cnt    <= '0;
                r_bit    <= LFSR_SEED[6];
                r_symbol <= level(LFSR_SEED[6]);
                r_lfsr   <= {LFSR_SEED[5:0], LFSR_SEED[6] ^ LFSR_SEED[5]};
              end else begin
                r_cnt    <= r_cnt + 12'd1;
                r_bit    <= w_sync_bit;
                r_symbol <= level(w_sync_bit);
              end
            end
            S_PAYLOAD: begin
              if (r_cnt == PAY_LAST) begin
                r_state  <= S_GAP;
                r_cnt    <= '0;
                r_bit    <= 1'b0;
                r_symbol <= '0;
              end else begin
                r_cnt    <= r_cnt + 12'd1;
                r_bit    <= r_lfsr[6];
                r_symbol <= level(r_lfsr[6]);
                r_lfsr   <= w_lfsr_next;
              end
            end
            S_GAP: begin
              r_cnt <= r_cnt + 12'd1;
            end
            default: begin
              r_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign symbol       = r_symbol;
  assign symbol_valid = r_symbol_valid;
  assign bit_out      = r_bit;
  assign frame_start  = r_frame_start;
  assign busy         = r_busy;
  assign state        = r_state;

endmodule

// File: tb/tb_bpsk_frame_generator.sv
// Bench for bpsk_frame_generator: a default instance and a no-gap / full-scale /
// fast-tick instance, checked symbol by symbol against a frame model.
module tb_bpsk_frame_generator;

  localparam int A_DIV   = 4;
  localparam int A_AMP   = 64;
  localparam int A_PL    = 64;
  localparam int A_GL    = 8;
  localparam int A_FRAME = 29 + A_PL + A_GL;
  localparam int B_DIV   = 2;
  localparam int B_AMP   = 127;
  localparam int B_PL    = 200;
  localparam int B_GL    = 0;
  localparam int B_FRAME = 29 + B_PL + B_GL;
  localparam int W       = 14;

  logic       clock = 1'b0;
  logic       rst_a_n, rst_b_n, en_a, en_b;
  logic [7:0] sym_a, sym_b;
  logic       sv_a, sv_b, bit_a, bit_b, fs_a, fs_b, busy_a, busy_b;
  logic [2:0] st_a, st_b;

  bpsk_frame_generator dut_a (
    .clock(clock), .reset_n(rst_a_n), .enable(en_a), .symbol(sym_a),
    .symbol_valid(sv_a), .bit_out(bit_a), .frame_start(fs_a), .busy(busy_a), .state(st_a)
  );

  bpsk_frame_generator #(
    .SYM_DIV(B_DIV), .AMPLITUDE(B_AMP), .SYNC_WORD(16'h1ACF),
    .PAYLOAD_LEN(B_PL), .GAP_LEN(B_GL)
  ) dut_b (
    .clock(clock), .reset_n(rst_b_n), .enable(en_b), .symbol(sym_b),
    .symbol_valid(sv_b), .bit_out(bit_b), .frame_start(fs_b), .busy(busy_b), .state(st_b)
  );

  // clock / cycle count
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rec;
    int           cyc;
  } cap_t;

  cap_t         a_q[$];
  cap_t         b_q[$];
  cap_t         chk_q[$];
  cap_t         mon_c;
  logic [W-1:0] exp_q[$];
  bit           prbs[0:511];
  logic [12:0]  barker_s = 13'b1111100110101;
  logic [15:0]  sync_w   = 16'h1ACF;
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic logic [W-1:0] pack(input logic bz, input logic [2:0] st, input logic fs,
                                        input logic b, input logic [7:0] s);
    return {bz, st, fs, b, s};
  endfunction

  // Every symbol_valid cycle is recorded with its cycle number
  always @(negedge clock) begin
    if (sv_a) begin
      mon_c.rec = pack(busy_a, st_a, fs_a, bit_a, sym_a);
      mon_c.cyc = cyc;
      a_q.push_back(mon_c);
    end
    if (sv_b) begin
      mon_c.rec = pack(busy_b, st_b, fs_b, bit_b, sym_b);
      mon_c.cyc = cyc;
      b_q.push_back(mon_c);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p, input logic [7:0] s, input logic v, input logic b,
                          input logic f, input logic bz, input logic [2:0] st);
    check({p, "_symbol"}, 32'(s), 0);
    check({p, "_valid"}, 32'(v), 0);
    check({p, "_bit"}, 32'(b), 0);
    check({p, "_fstart"}, 32'(f), 0);
    check({p, "_busy"}, 32'(bz), 0);
    check({p, "_state"}, 32'(st), 0);
  endtask

  // PRBS7 from the recurrence b[n+7] = b[n] ^ b[n+1], seeded with seven ones
  function automatic void build_prbs();
    for (int n = 0; n < 7; n++) prbs[n] = 1'b1;
    for (int n = 0; n + 7 < 512; n++) prbs[n+7] = prbs[n] ^ prbs[n+1];
  endfunction

  // Expected records for the first 'upto' symbols of one frame
  task automatic push_frame(input int amp, input int pl, input int gl, input int upto);
    logic [2:0] st;
    logic       b;
    int         lvl;
    for (int p = 0; p < upto && p < 29 + pl + gl; p++) begin
      if (p < 13) begin
        st = 3'd1; b = barker_s[12-p];
      end else if (p < 29) begin
        st = 3'd2; b = sync_w[15-(p-13)];
      end else if (p < 29 + pl) begin
        st = 3'd3; b = prbs[p-29];
      end else begin
        st = 3'd4; b = 1'b0;
      end
      lvl = (st == 3'd4) ? 0 : (b ? -amp : amp);
      exp_q.push_back(pack(1'b1, st, (p == 0), b, 8'(lvl)));
    end
  endtask

  task automatic compare(input string name, input int sdiv);
    int n;
    check({name, "_count"}, chk_q.size(), exp_q.size());
    n = (chk_q.size() < exp_q.size()) ? chk_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_sym%0d", name, i), 32'(chk_q[i].rec), 32'(exp_q[i]));
      if (i > 0)
        check($sformatf("%s_gap%0d", name, i), chk_q[i].cyc - chk_q[i-1].cyc, sdiv);
    end
  endtask

  task automatic wait_size(input string tag, input bit use_b, input int n, input int budget);
    int k;
    k = 0;
    while (((use_b ? b_q.size() : a_q.size()) < n) && (k < budget)) begin
      @(posedge clock); #2;
      k++;
    end
    check(tag, 32'((use_b ? b_q.size() : a_q.size()) >= n), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d, r, k;
    build_prbs();
    rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0;

    // reset state
    repeat (4) @(posedge clock);
    #2;
    chk_zero("rst_a", sym_a, sv_a, bit_a, fs_a, busy_a, st_a);
    chk_zero("rst_b", sym_b, sv_b, bit_b, fs_b, busy_b, st_b);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // continuous framing with an enable dip inside frame 0 and re-assert in its gap
    repeat ($urandom_range(9, 0)) @(posedge clock);
    #2;
    c0 = cyc;
    en_a = 1'b1;
    d = $urandom_range(90, 1);
    r = $urandom_range(101, 94);
    wait_size("a_dip_start", 1'b0, d, 1000);
    en_a = 1'b0;
    wait_size("a_dip_end", 1'b0, r, 1000);
    en_a = 1'b1;
    wait_size("a_payload10", 1'b0, 2 * A_FRAME + 29 + 11, 2000);
    en_a = 1'b0;
    wait_size("a_drain", 1'b0, 3 * A_FRAME + 1, 2000);
    repeat (40) @(posedge clock);
    #2;
    check("a_latency", 32'((a_q[0].cyc - c0 >= 1) && (a_q[0].cyc - c0 <= A_DIV)), 1);
    check("a_first_level", 32'(a_q[0].rec[7:0]), 32'h0000_00C0);
    check("a_fs_period", a_q[A_FRAME].cyc - a_q[0].cyc, A_FRAME * A_DIV);
    check("a_idle_busy", 32'(busy_a), 0);
    check("a_idle_symbol", 32'(sym_a), 0);
    check("a_idle_state", 32'(st_a), 0);
    exp_q.delete();
    for (int f = 0; f < 3; f++) push_frame(A_AMP, A_PL, A_GL, A_FRAME);
    exp_q.push_back(pack(1'b0, 3'd0, 1'b0, 1'b0, 8'd0));
    chk_q = a_q;
    compare("a_run", A_DIV);

    // asynchronous reset in SYNC, then restart from the preamble
    a_q.delete();
    en_a = 1'b1;
    k = 0;
    while ((st_a !== 3'd2) && (k < 200)) begin
      @(posedge clock); #2;
      k++;
    end
    check("a_reach_sync", 32'(st_a), 2);
    check("a_sync_busy", 32'(busy_a), 1);
    #($urandom_range(2, 1));
    rst_a_n = 1'b0;
    #1;
    chk_zero("arst_a", sym_a, sv_a, bit_a, fs_a, busy_a, st_a);
    repeat (3) @(posedge clock);
    #2;
    a_q.delete();
    rst_a_n = 1'b1;
    wait_size("a_restart", 1'b0, 30, 400);
    en_a = 1'b0;
    exp_q.delete();
    push_frame(A_AMP, A_PL, A_GL, 30);
    chk_q = a_q;
    compare("a_restart", A_DIV);

    // no gap, full scale, two-clock symbols, long payload for the PRBS period
    b_q.delete();
    en_b = 1'b1;
    wait_size("b_two_frames", 1'b1, 2 * B_FRAME, 3000);
    en_b = 1'b0;
    chk_q = b_q;
    exp_q.delete();
    push_frame(B_AMP, B_PL, B_GL, B_FRAME);
    push_frame(B_AMP, B_PL, B_GL, B_FRAME);
    compare("b_run", B_DIV);
    check("b_wrap_level", 32'(chk_q[B_FRAME].rec[7:0]), 32'h0000_0081);
    check("b_wrap_fstart", 32'(chk_q[B_FRAME].rec[9]), 1);
    check("b_wrap_spacing", chk_q[B_FRAME].cyc - chk_q[B_FRAME-1].cyc, B_DIV);
    check("b_prbs_period", 32'(chk_q[29+127].rec[8]), 32'(prbs[0]));
    check("b_fs_period", chk_q[B_FRAME].cyc - chk_q[0].cyc, B_FRAME * B_DIV);
    repeat (10) @(posedge clock);
    #2;
    check("b_idle_state", 32'(st_b), 0);
    check("b_idle_symbol", 32'(sym_b), 0);
    check("b_idle_busy", 32'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
